// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store,
// generating byte lanes for stores, extending load data and flagging misalignment/timeouts.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX  = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_stall,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_ldst,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        d_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D, ERR_D} state_e;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam bit         TMO_EN     = (TIMEOUT_CYC != 0);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mreq_q, mreq_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ldst_q, ldst_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        d_misaligned;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;
    logic        grant_i, grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
            mreq_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            ldst_q   <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            mreq_q   <= mreq_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            ldst_q   <= ldst_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Request-side decode works on the live d_* inputs; load extraction uses the latched op/offset.
    always_comb begin
        d_misaligned = 1'b0;
        st_we        = '0;
        st_wdata     = '0;
        case (d_ldst)
            OP_LH, OP_LHU: d_misaligned = d_addr[0];
            OP_LW:         d_misaligned = |d_addr[1:0];
            OP_SB: begin
                st_we    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            OP_SH: begin
                d_misaligned = d_addr[0];
                st_we        = 4'b0011 << d_addr[1:0];
                st_wdata     = {2{d_wdata[15:0]}};
            end
            OP_SW: begin
                d_misaligned = |d_addr[1:0];
                st_we        = 4'b1111;
                st_wdata     = d_wdata;
            end
            default: ;
        endcase

        ld_shift = mem_rdata >> {off_q, 3'b000};
        ld_data  = '0;
        case (ldst_q)
            OP_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            OP_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            OP_LW:   ld_data = mem_rdata;
            OP_LBU:  ld_data = {24'h0, ld_shift[7:0]};
            OP_LHU:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        mreq_d   = mreq_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        ldst_d   = ldst_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        grant_i  = i_req && (!d_req || starve_q == STARVE_LIM);
        grant_d  = d_req && !grant_i;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    if (i_req && starve_q != 4'hF) starve_d = starve_q + 4'd1;
                    ldst_d  = d_ldst;
                    off_d   = d_addr[1:0];
                    tmo_d   = '0;
                    rdata_d = '0;
                    err_d   = d_misaligned;
                    if (d_misaligned) begin
                        state_d = ERR_D;
                    end else begin
                        state_d = BUSY_D;
                        mreq_d  = 1'b1;
                        addr_d  = {d_addr[31:2], 2'b00};
                        we_d    = st_we;
                        wdata_d = st_wdata;
                    end
                end else if (grant_i) begin
                    starve_d = '0;
                    tmo_d    = '0;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = BUSY_I;
                    mreq_d   = 1'b1;
                    addr_d   = {i_addr[31:2], 2'b00};
                    we_d     = '0;
                    wdata_d  = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    mreq_d  = 1'b0;
                    we_d    = '0;
                    rdata_d = (state_q == BUSY_D) ? ld_data : mem_rdata;
                    state_d = (state_q == BUSY_D) ? RESP_D : RESP_I;
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    mreq_d  = 1'b0;
                    we_d    = '0;
                    rdata_d = '0;
                    err_d   = (state_q == BUSY_D);
                    state_d = (state_q == BUSY_D) ? RESP_D : RESP_I;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_valid   = (state_q == RESP_I);
        d_valid   = (state_q == RESP_D) || (state_q == ERR_D);
        d_err     = (state_q == ERR_D) || ((state_q == RESP_D) && err_q);
        i_rdata   = i_valid ? rdata_q : '0;
        d_rdata   = (state_q == RESP_D) ? rdata_q : '0;
        i_stall   = i_req & ~i_valid;
        d_stall   = d_req & ~d_valid;
        mem_req   = mreq_q;
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_wdata = wdata_q;
    end

endmodule
